gray_count_receiver: RTL
========================

// Module: gray_count_receiver
// PURPOSE
//  Consumer stage for the 4-bit Gray counter output, in an unrelated clock domain.
//  Synchronises the Gray bus and converts it to binary.
//  Checks that each observed change is exactly one legal +1 step.
//  Counts steps, flags wrap-around, and latches a sticky fault on any illegal transition.
// PARAMETERS
//  WIDTH        4  Gray/binary count width.
//  SYNC_STAGES  2  Synchroniser flop depth, >=2.
//  ACC_WIDTH    8  Width of the accumulated step counter.
// PORTS
//  Clk_In          in   1          Receiver clock; posedge only.
//  Reset_In        in   1          Reset, asynchronous, active-high.
//  Gray_Count_In   in   WIDTH      Gray count from the upstream counter's domain.
//  Clear_Err_In    in   1          Fault clear and re-baseline; level sampled on posedge.
//  Binary_Out      out  WIDTH      Registered binary value of the synchronised Gray input.
//  Step_Pulse_Out  out  1          1-cycle pulse per legal +1 step.
//  Wrap_Pulse_Out  out  1          1-cycle pulse on the legal step from max to 0.
//  Step_Count_Out  out  ACC_WIDTH  Total legal steps since reset; wraps modulo 2^ACC_WIDTH.
//  Locked_Out      out  1          1 while in TRACK state.
//  Error_Out       out  1          Sticky illegal-transition flag.
// BEHAVIOUR
//  Reset: all outputs 0, synchroniser flops 0, prev register 0, fill counter 0, state SEED.
//  Sync: Gray_Count_In passes through a SYNC_STAGES flop chain; sync = last stage. No binary conversion before sync.
//  g2b: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
//  SEED:
//   - Fill counter increments each clock.
//   - On the clock where fill == SYNC_STAGES-1: prev<=sync; Binary_Out<=g2b(sync); Locked_Out<=1; ->TRACK.
//   - No pulses are generated during SEED.
//  TRACK, each clock, with d = sync ^ prev:
//   - d==0: hold all outputs; pulses 0.
//   - g2b(sync) == g2b(prev)+1 mod 2^WIDTH (legal step; necessarily one bit of d set):
//     prev<=sync; Binary_Out<=g2b(sync); Step_Pulse_Out<=1; Step_Count_Out<=+1.
//     If g2b(prev) == 2^WIDTH-1, also Wrap_Pulse_Out<=1.
//   - Any other d!=0 (multi-bit change, backward step, non-adjacent jump):
//     Error_Out<=1; Locked_Out<=0; ->FAULT. Step_Count_Out and Binary_Out unchanged; no pulse.
//   - Clear_Err_In is ignored in TRACK.
//  FAULT:
//   - prev<=sync and Binary_Out<=g2b(sync) every clock, with no legality checks and no pulses.
//   - Clear_Err_In=1: Error_Out<=0; prev<=sync; Locked_Out<=1; ->TRACK.
//     A change present on sync in that same cycle is absorbed into the baseline; no pulse.
//  Latency: input change to Binary_Out / Step_Pulse_Out update = SYNC_STAGES+1 posedges.
//  Input stability: upstream must hold each code for >= SYNC_STAGES+1 receiver clocks.
//   Faster upstream stepping yields multi-bit deltas, which are flagged as errors by design.
//  Step_Count_Out wraps from 2^ACC_WIDTH-1 to 0 silently; there is no overflow flag.
//  Step_Pulse_Out and Wrap_Pulse_Out are registered and never high for two consecutive cycles from one step.
//  Reset mid-operation: async clear of everything; SEED restarts after deassert.
// TESTING  (WIDTH=4, SYNC_STAGES=2, ACC_WIDTH=8, input held >=4 clocks per code)
//  1. Release reset, input 0000 -> Locked_Out=1 after 2nd posedge; Binary_Out=0; Error_Out=0; no pulses.
//  2. Drive Gray 0..15 then 1000->0000 -> 16 Step pulses; Step_Count_Out=16;
//     exactly one Wrap pulse (on 1000->0000); Binary_Out tracks 0..15,0 with 3-clock lag.
//  3. Baseline 0000, drive 0011 (two bits) -> Error_Out=1 and Locked_Out=0 3 clocks later;
//     Step_Count_Out unchanged; no pulse.
//  4. Baseline 0011 (bin 2), drive 0001 (bin 1, single bit, backward) -> Error_Out=1; no pulse.
//  5. In FAULT with input 0110 (bin 4), pulse Clear_Err_In -> Error_Out=0; Locked_Out=1; Binary_Out=4; no pulse;
//     then 0111 -> one Step pulse; Binary_Out=5.
//  6. Assert Reset_In mid-count (Step_Count_Out=9) -> all outputs 0 immediately, before the next clock;
//     after release, SEED re-locks per test 1.

Source files
------------

// File: rtl/gray_count_receiver.sv
// Receiver for a Gray-coded up-counter arriving from a foreign clock domain:
// synchronises, converts to binary, validates +1 steps and counts them.
module gray_count_receiver #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACC_WIDTH   = 8
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  input  logic [WIDTH-1:0]     Gray_Count_In,
  input  logic                 Clear_Err_In,
  output logic [WIDTH-1:0]     Binary_Out,
  output logic                 Step_Pulse_Out,
  output logic                 Wrap_Pulse_Out,
  output logic [ACC_WIDTH-1:0] Step_Count_Out,
  output logic                 Locked_Out,
  output logic                 Error_Out
);

  localparam int unsigned FILL_W    = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
  localparam int unsigned FILL_LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             state_q;
  logic [FILL_W-1:0]  fill_q;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];

  logic [WIDTH-1:0]   sync_c;
  logic [WIDTH-1:0]   sync_bin_c;
  logic [WIDTH-1:0]   prev_bin_c;
  logic               changed_c;
  logic               legal_c;
  logic               at_max_c;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Raw Gray bus is resynchronised as-is; only one bit moves per legal step.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= Gray_Count_In;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Step legality is judged in the binary domain against the last accepted code.
  always_comb begin
    sync_c     = sync_q[SYNC_STAGES-1];
    sync_bin_c = g2b(sync_c);
    prev_bin_c = g2b(prev_q);
    changed_c  = |(sync_c ^ prev_q);
    legal_c    = (sync_bin_c == (prev_bin_c + WIDTH'(1)));
    at_max_c   = &prev_bin_c;
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q        <= SEED;
      fill_q         <= '0;
      prev_q         <= '0;
      Binary_Out     <= '0;
      Step_Pulse_Out <= 1'b0;
      Wrap_Pulse_Out <= 1'b0;
      Step_Count_Out <= '0;
      Locked_Out     <= 1'b0;
      Error_Out      <= 1'b0;
    end else begin
      Step_Pulse_Out <= 1'b0;
      Wrap_Pulse_Out <= 1'b0;
      case (state_q)
        SEED: begin
          fill_q <= fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(FILL_LAST)) begin
            prev_q     <= sync_c;
            Binary_Out <= sync_bin_c;
            Locked_Out <= 1'b1;
            state_q    <= TRACK;
          end
        end
        TRACK: begin
          if (changed_c) begin
            if (legal_c) begin
              prev_q         <= sync_c;
              Binary_Out     <= sync_bin_c;
              Step_Pulse_Out <= 1'b1;
              Wrap_Pulse_Out <= at_max_c;
              Step_Count_Out <= Step_Count_Out + ACC_WIDTH'(1);
            end else begin
              Error_Out  <= 1'b1;
              Locked_Out <= 1'b0;
              state_q    <= FAULT;
            end
          end
        end
        FAULT: begin
          // Follow the input blindly so a clear re-baselines on the current code.
          prev_q     <= sync_c;
          Binary_Out <= sync_bin_c;
          if (Clear_Err_In) begin
            Error_Out  <= 1'b0;
            Locked_Out <= 1'b1;
            state_q    <= TRACK;
          end
        end
        default: begin
          state_q <= SEED;
        end
      endcase
    end
  end

endmodule
